// File: rtl/tmr_seg7_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tmr_seg7_unit_pkg
// Description : Shared constants for the timer / 7-segment helper block:
//               default counter width and the hex-to-segment code table.
// Revision    : 1.0  initial release
// ============================================================================
package tmr_seg7_unit_pkg;

    // Default timer width; the timer load value has the same width.
    localparam int DEF_CNT_W = 32;

    // Width of one 7-segment digit (bit0 = a ... bit6 = g).
    localparam int SEG_W = 7;

    // Active-low segment codes for hex digits 0..F (g..a order).
    // Letters render as A, b, C, d, E, F.
    localparam logic [SEG_W-1:0] c_HEX_SEG_AL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Look up the active-low segment pattern for one nibble.
    function automatic logic [SEG_W-1:0] hex_to_seg_al(input logic [3:0] nib);
        return c_HEX_SEG_AL[nib];
    endfunction

endpackage : tmr_seg7_unit_pkg
`default_nettype wire

// File: rtl/tmr_seg7_unit_hex7_dec.sv
`default_nettype none
// ============================================================================
// Module      : hex7_dec
// Description : Combinational hex nibble to 7-segment decoder. Output
//               polarity selected by SEG_ACTIVE_LOW (1 = 0 lights a segment).
// Revision    : 1.0  initial release
// ============================================================================
module hex7_dec
    import tmr_seg7_unit_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic [3:0]       nib,
    output logic [SEG_W-1:0] seg
);

    logic [SEG_W-1:0] w_seg_al;

    // Table lookup gives the active-low pattern directly.
    always_comb begin
        w_seg_al = hex_to_seg_al(nib);
    end

    generate
        if (SEG_ACTIVE_LOW) begin : g_active_low
            assign seg = w_seg_al;
        end else begin : g_active_high
            assign seg = ~w_seg_al;
        end
    endgenerate

endmodule : hex7_dec
`default_nettype wire

// File: rtl/tmr_seg7_unit.sv
`default_nettype none
// ============================================================================
// Module      : tmr_seg7_unit
// Description : Peripheral helper for the MIPS device controller.
//               - Programmable down-counting timer with a registered
//                 one-cycle expiry pulse (tmr_req).
//               - 8-bit display latch driving two hex 7-segment digits.
//               Build option: TMR_AUTO_RELOAD_EN - when defined the counter
//               reloads from the reload register at expiry (periodic mode);
//               otherwise the timer is one-shot and parks at zero.
// Revision    : 1.0  initial release
// ============================================================================
module tmr_seg7_unit
    import tmr_seg7_unit_pkg::*;
#(
    parameter int CNT_W          = DEF_CNT_W,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active-low
    input  logic [CNT_W-1:0] din,
    input  logic             ld,
    input  logic             clr,
    input  logic             tmr_en,
    output logic             tmr_req,
    output logic [CNT_W-1:0] cntr_o,
    input  logic             seg_wr,
    input  logic [7:0]       seg_din,
    output logic [SEG_W-1:0] seg7led1,
    output logic [SEG_W-1:0] seg7led2
);

    localparam logic [CNT_W-1:0] c_ZERO = '0;
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // Timer state
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_cntr;
    logic [CNT_W-1:0] r_reload;
    logic             r_req;

    logic             w_cnt_active;   // enabled count step this cycle
    logic             w_at_one;       // counter about to reach zero
    logic             w_expire;       // expiry event, registered into tmr_req
    logic [CNT_W-1:0] w_expire_val;   // counter value taken at expiry
    logic [CNT_W-1:0] w_cntr_nxt;

    assign w_at_one     = (r_cntr == c_ONE);
    // clr and ld both override the count step, so neither may count.
    assign w_cnt_active = tmr_en && !clr && !ld && (r_cntr != c_ZERO);
    assign w_expire     = w_cnt_active && w_at_one;

`ifdef TMR_AUTO_RELOAD_EN
    // Periodic mode: restart from the last loaded value at expiry.
    assign w_expire_val = r_reload;
`else
    // One-shot mode: park at zero until software loads a new value.
    assign w_expire_val = c_ZERO;
`endif

    // Next counter value: clr > ld > count > hold.
    always_comb begin
        w_cntr_nxt = r_cntr;
        if (clr) begin
            w_cntr_nxt = c_ZERO;
        end else if (ld) begin
            w_cntr_nxt = din;
        end else if (w_cnt_active) begin
            if (w_at_one) begin
                w_cntr_nxt = w_expire_val;
            end else begin
                w_cntr_nxt = r_cntr - c_ONE;
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cntr <= c_ZERO;
        end else begin
            r_cntr <= w_cntr_nxt;
        end
    end

    // Reload register: written only by a load that is not overridden by clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reload <= c_ZERO;
        end else if (ld && !clr) begin
            r_reload <= din;
        end
    end

    // Expiry pulse: high for exactly the cycle after the 1 -> 0/reload step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req <= 1'b0;
        end else begin
            r_req <= w_expire;
        end
    end

    assign tmr_req = r_req;
    assign cntr_o  = r_cntr;

    // ------------------------------------------------------------------
    // Display latch and digit decode
    // ------------------------------------------------------------------
    logic [7:0] r_disp;

    // Display register captures the byte written by the CPU store path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_disp <= 8'h00;
        end else if (seg_wr) begin
            r_disp <= seg_din;
        end
    end

    hex7_dec #(
        .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
    ) u_dec_lo (
        .nib (r_disp[3:0]),
        .seg (seg7led1)
    );

    hex7_dec #(
        .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
    ) u_dec_hi (
        .nib (r_disp[7:4]),
        .seg (seg7led2)
    );

endmodule : tmr_seg7_unit
`default_nettype wire

// File: tb/tb_tmr_seg7_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_tmr_seg7_unit
// Description : Directed, table-driven self-checking bench for tmr_seg7_unit.
// Revision    : 1.0  initial release
// ============================================================================
module tb_tmr_seg7_unit;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] din;
    logic             ld, clr, tmr_en, seg_wr;
    logic [7:0]       seg_din;
    logic             tmr_req;
    logic [CNT_W-1:0] cntr_o;
    logic [6:0]       seg7led1, seg7led2;

    int n_checks = 0;
    int n_fail   = 0;

    tmr_seg7_unit #(
        .CNT_W          (CNT_W),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .ld       (ld),
        .clr      (clr),
        .tmr_en   (tmr_en),
        .tmr_req  (tmr_req),
        .cntr_o   (cntr_o),
        .seg_wr   (seg_wr),
        .seg_din  (seg_din),
        .seg7led1 (seg7led1),
        .seg7led2 (seg7led2)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        clr;
        logic        ld;
        logic        en;
        logic [31:0] din;
        logic        seg_wr;
        logic [7:0]  seg_din;
        logic [31:0] exp_cntr;
        logic        exp_req;
        logic [6:0]  exp_s1;
        logic [6:0]  exp_s2;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic c, input logic l, input logic e,
                       input logic [31:0] d, input logic sw, input logic [7:0] sd,
                       input logic [31:0] ec, input logic er,
                       input logic [6:0] s1, input logic [6:0] s2);
        vec_t v;
        v.name = name; v.clr = c; v.ld = l; v.en = e; v.din = d;
        v.seg_wr = sw; v.seg_din = sd; v.exp_cntr = ec; v.exp_req = er;
        v.exp_s1 = s1; v.exp_s2 = s2;
        vq.push_back(v);
    endtask

    task automatic drive(input logic c, input logic l, input logic e,
                         input logic [31:0] d, input logic sw, input logic [7:0] sd);
        clr = c; ld = l; tmr_en = e; din = d; seg_wr = sw; seg_din = sd;
    endtask

    // Apply inputs, clock once, sample 1 time unit after the edge.
    task automatic step_check(input vec_t v);
        drive(v.clr, v.ld, v.en, v.din, v.seg_wr, v.seg_din);
        @(posedge clk); #1;
        chk({v.name, "/cntr"}, cntr_o, v.exp_cntr);
        chk({v.name, "/req"},  {31'd0, tmr_req}, {31'd0, v.exp_req});
        chk({v.name, "/seg1"}, {25'd0, seg7led1}, {25'd0, v.exp_s1});
        chk({v.name, "/seg2"}, {25'd0, seg7led2}, {25'd0, v.exp_s2});
    endtask

    initial begin
        // ---------------- vector table ----------------
        // name          clr ld en din  sw sd     cntr req s1     s2
        add("ld3",        0, 1, 0, 3,   0, 8'h00, 3,  0, 7'h40, 7'h40);
        add("cnt3-2",     0, 0, 1, 0,   0, 8'h00, 2,  0, 7'h40, 7'h40);
        add("cnt2-1",     0, 0, 1, 0,   0, 8'h00, 1,  0, 7'h40, 7'h40);
`ifdef TMR_AUTO_RELOAD_EN
        add("expire",     0, 0, 1, 0,   0, 8'h00, 3,  1, 7'h40, 7'h40);
        add("post1",      0, 0, 1, 0,   0, 8'h00, 2,  0, 7'h40, 7'h40);
        add("post2",      0, 0, 1, 0,   0, 8'h00, 1,  0, 7'h40, 7'h40);
`else
        add("expire",     0, 0, 1, 0,   0, 8'h00, 0,  1, 7'h40, 7'h40);
        add("post1",      0, 0, 1, 0,   0, 8'h00, 0,  0, 7'h40, 7'h40);
        add("post2",      0, 0, 1, 0,   0, 8'h00, 0,  0, 7'h40, 7'h40);
`endif
        add("ldclr",      1, 1, 0, 9,   0, 8'h00, 0,  0, 7'h40, 7'h40);
        add("ldclr_hold", 0, 0, 1, 0,   0, 8'h00, 0,  0, 7'h40, 7'h40);
        add("segA5",      0, 0, 0, 0,   1, 8'hA5, 0,  0, 7'h12, 7'h08);
        add("segF0",      0, 0, 0, 0,   1, 8'hF0, 0,  0, 7'h40, 7'h0E);
        add("seghold",    0, 0, 0, 0,   0, 8'h33, 0,  0, 7'h40, 7'h0E);
        add("ld0",        0, 1, 1, 0,   0, 8'h00, 0,  0, 7'h40, 7'h0E);
        add("ld0_en1",    0, 0, 1, 0,   0, 8'h00, 0,  0, 7'h40, 7'h0E);
        add("ld0_en2",    0, 0, 1, 0,   0, 8'h00, 0,  0, 7'h40, 7'h0E);
        add("ld2",        0, 1, 0, 2,   0, 8'h00, 2,  0, 7'h40, 7'h0E);
        add("ld2_cnt",    0, 0, 1, 0,   0, 8'h00, 1,  0, 7'h40, 7'h0E);
        add("clr_at1",    1, 0, 1, 0,   0, 8'h00, 0,  0, 7'h40, 7'h0E);
        add("clr_after",  0, 0, 1, 0,   0, 8'h00, 0,  0, 7'h40, 7'h0E);
        add("ld_at1",     0, 1, 0, 1,   0, 8'h00, 1,  0, 7'h40, 7'h0E);
        add("ld_ovr_exp", 0, 1, 1, 6,   0, 8'h00, 6,  0, 7'h40, 7'h0E);

        // ---------------- reset state ----------------
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        chk("rst/cntr", cntr_o, 0);
        chk("rst/req",  {31'd0, tmr_req}, 0);
        chk("rst/seg1", {25'd0, seg7led1}, 32'h40);
        chk("rst/seg2", {25'd0, seg7led2}, 32'h40);
        rst = 1'b1;

        // ---------------- table pass ----------------
        foreach (vq[i]) step_check(vq[i]);

        // ---------------- tmr_en=0 hold for 10 cycles ----------------
        drive(0, 1, 0, 7, 0, 8'h00);
        @(posedge clk); #1;
        chk("ld7/cntr", cntr_o, 7);
        drive(0, 0, 0, 0, 0, 8'h00);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk($sformatf("hold7_%0d/cntr", k), cntr_o, 7);
            chk($sformatf("hold7_%0d/req", k), {31'd0, tmr_req}, 0);
        end

        // ---------------- periodic / one-shot run from ld 4 ----------------
        drive(0, 1, 0, 4, 0, 8'h00);
        @(posedge clk); #1;
        chk("ld4/cntr", cntr_o, 4);
        drive(0, 0, 1, 0, 0, 8'h00);
        for (int k = 1; k <= 10; k++) begin
            logic [31:0] ec;
            logic        er;
`ifdef TMR_AUTO_RELOAD_EN
            ec = 32'(4 - (k % 4));          // 3,2,1,4,3,2,1,4,...
            er = (k % 4 == 0);
`else
            ec = (k < 4) ? 32'(4 - k) : 32'd0;
            er = (k == 4);
`endif
            @(posedge clk); #1;
            chk($sformatf("run4_%0d/cntr", k), cntr_o, ec);
            chk($sformatf("run4_%0d/req", k), {31'd0, tmr_req}, {31'd0, er});
        end

        // ---------------- asynchronous reset mid-count ----------------
        drive(0, 1, 0, 5, 1, 8'hA5);
        @(posedge clk); #1;
        chk("ld5/cntr", cntr_o, 5);
        drive(0, 0, 0, 0, 0, 8'h00);
        #2;
        rst = 1'b0;        // between edges: must take effect without a clock
        #1;
        chk("arst/cntr", cntr_o, 0);
        chk("arst/req",  {31'd0, tmr_req}, 0);
        chk("arst/seg1", {25'd0, seg7led1}, 32'h40);
        chk("arst/seg2", {25'd0, seg7led2}, 32'h40);
        @(posedge clk); #1;
        rst = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_tmr_seg7_unit
`default_nettype wire

// File: doc/tmr_seg7_unit.md
Name: tmr_seg7_unit

Overview:
Peripheral helper block for the MIPS device controller (mips_dvc).
- 32-bit programmable down-counting timer with a one-cycle interrupt request pulse (tmr0 function).
- 8-bit display latch driving two hex 7-segment digits (seg7led_cv function).
- The CPU store path drives ld/seg_wr. The controller's cmd register drives clr/tmr_en. tmr_req feeds the IRQ logic, gated there by cmd[31].

Parameters:
- CNT_W, 32: timer/counter width; din width equals CNT_W.
- SEG_ACTIVE_LOW, 1: 1 = segment outputs active-low (0 lights the segment); 0 = active-high.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- din  in  CNT_W  timer load value.
- ld  in  1  load counter and reload register from din.
- clr  in  1  synchronous counter clear (cmd[7]).
- tmr_en  in  1  count enable (cmd[8]).
- tmr_req  out  1  registered one-cycle expiry pulse.
- cntr_o  out  CNT_W  current counter value.
- seg_wr  in  1  latch seg_din into display register.
- seg_din  in  8  display byte.
- seg7led1  out  7  low-nibble digit, bit0=a … bit6=g.
- seg7led2  out  7  high-nibble digit, same bit order.

Behaviour:
- Reset (rst=0, asynchronous):
  - counter = 0, reload = 0, tmr_req = 0, display register = 0.
  - seg outputs therefore show "00".
- Counter update priority per cycle: clr > ld > count.
  - clr: counter <= 0; reload register unchanged; tmr_req <= 0.
  - ld (clr=0): counter <= din; reload <= din; tmr_req <= 0.
  - count (tmr_en=1, counter!=0): counter <= counter-1.
  - tmr_en=0: counter holds.
  - counter==0 with tmr_en=1: holds at 0, no request.
- Expiry: when tmr_en=1, no clr/ld, and counter==1, tmr_req=1 in the following cycle for exactly one cycle. Otherwise tmr_req=0.
  - Latency: load N, enable continuously → tmr_req high in the cycle after the N-th enabled edge.
- Loading 0 never produces a request.
- Simultaneous ld and clr: clr wins; the reload register is not written.
- cntr_o = counter register directly (no extra latency).
- Display register: seg_wr=1 latches seg_din at the clock edge.
- Digit decode is combinational from the display register.
- Active-low hex codes (g..a order), digits 0-F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E. Letters render as A,b,C,d,E,F.
- SEG_ACTIVE_LOW=0 outputs the bitwise inverse of these codes.

Optional Feature:
- Macro TMR_AUTO_RELOAD_EN.
- Defined: at expiry (counter==1, enabled), counter <= reload instead of 0. This gives a periodic tmr_req every reload cycles. If reload==1, tmr_req pulses every enabled cycle.
- Undefined: one-shot; counter stops at 0 until the next ld.
- tmr_req timing is identical in both builds.

Decomposition:
- Shared package/defines file: the 16-entry hex-to-segment constant table and the CNT_W default. Address/ctl codes stay in mips789_defs.
- One natural sub-module: hex7_dec (4-bit nibble in, 7-bit segments out, SEG_ACTIVE_LOW parameter), instantiated twice.
- Timer logic stays inline.

Test Plan:
- Reset mid-count: counter at 5, assert rst=0 asynchronously → cntr_o=0, tmr_req=0 immediately; seg7led1=seg7led2=7'h40.
- ld din=3, tmr_en=1 → cntr_o 3,2,1,0 on successive edges; tmr_req=1 only in the cycle cntr_o first reads 0. Without macro: stays 0, no further pulses.
- With TMR_AUTO_RELOAD_EN, ld din=4, enable → tmr_req pulses every 4 cycles; cntr_o sequence 4,3,2,1,4,3...
- Priority: ld=1 and clr=1 with din=9 → cntr_o=0, reload unchanged. tmr_en=0 for 10 cycles after ld 7 → cntr_o holds 7, no req.
- seg_wr with seg_din=8'hA5 → seg7led1=7'h12 ("5"), seg7led2=7'h08 ("A"). seg_din=8'hF0 → 7'h40 / 7'h0E.
- clr asserted in the cycle counter==1 → counter 0, tmr_req stays 0.
